// File: rtl/dot_accum_if.sv
// -----------------------------------------------------------------------------
// dot_accum_if
//   Bundles the beat-side and result-side handshakes of dot_accum.
//
//   Handshake rule (both channels): a transfer happens on the rising edge
//   where valid & ready are both 1. The producer holds its payload stable
//   while valid & !ready. ready may depend combinationally on the other
//   side's signals, valid never depends on ready.
//
//   Signals
//     in_valid   upstream presents a beat on the multiplier a/b this cycle
//     in_last    the beat closes a frame
//     in_ready   dot_accum can absorb the product of this beat
//     prod       multiplier output, unsigned, arrives MUL_LAT edges later
//     out_valid  result register holds a completed frame
//     out_ready  consumer takes the result
//     out_data   frame sum, saturated
//     out_ovf    frame sum saturated
//     out_count  beats in frame, saturating at 16'hFFFF
//
//   Modports
//     slave   the dot_accum side
//     master  the environment side (beat source, multiplier, result sink)
// -----------------------------------------------------------------------------
interface dot_accum_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
);
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;
  logic [15:0]       out_count;

  modport slave (
    input  in_valid,
    input  in_last,
    input  prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output out_count
  );

  modport master (
    output in_valid,
    output in_last,
    output prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  out_count
  );
endinterface

// File: rtl/dot_accum.sv
// -----------------------------------------------------------------------------
// dot_accum
//   Consumer of a fixed-latency multiplier product stream. Tracks each
//   accepted beat through the multiplier latency with a {valid,last} delay
//   line, accumulates the products of a frame into a saturating unsigned sum
//   and presents the finished frame on a valid/ready result register.
//
//   The multiplier cannot stall, so in_ready is withheld whenever a product
//   could arrive with nowhere to go: while the result register is full and
//   not being taken, and while a frame-closing beat is still in flight.
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        synchronous active-low reset
//     bus          dot_accum_if.slave (beat handshake, prod, result handshake)
//     o_dbg_state  1 while a frame is open (ACCUM), 0 in IDLE
//
//   Parameters
//     PROD_W   product width
//     ACC_W    accumulator / result width, > PROD_W
//     MUL_LAT  edges from beat acceptance to product consumption, >= 1
// -----------------------------------------------------------------------------
module dot_accum #(
  parameter int PROD_W  = 32,
  parameter int ACC_W   = 40,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  dot_accum_if.slave  bus,
  output logic        o_dbg_state
);

  generate
    if (ACC_W <= PROD_W) begin : g_bad_acc_w
      $error("dot_accum: ACC_W must be greater than PROD_W");
    end
    if (MUL_LAT < 1) begin : g_bad_lat
      $error("dot_accum: MUL_LAT must be at least 1");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             r_state;

  // Delay line: index 0 is written on the accepting edge, index MUL_LAT-1
  // qualifies prod on the following edge.
  logic [MUL_LAT-1:0] r_dl_valid;
  logic [MUL_LAT-1:0] r_dl_last;

  logic [ACC_W-1:0]   r_acc;
  logic [15:0]        r_cnt;
  logic               r_ovf;

  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic               r_out_ovf;
  logic [15:0]        r_out_count;

  logic               w_accept;
  logic               w_any_last;
  logic               w_fin_valid;
  logic               w_fin_last;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_acc_base;
  logic [ACC_W:0]     w_sum_full;
  logic               w_ovf_next;
  logic [ACC_W-1:0]   w_acc_next;
  logic [15:0]        w_cnt_base;
  logic [15:0]        w_cnt_next;
  logic               w_take;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // A last beat in flight blocks new beats until its result has been loaded,
  // which guarantees the result register is empty when that last arrives.
  assign w_any_last   = |r_dl_last;
  assign bus.in_ready = rst_n & ~(r_out_valid & ~bus.out_ready) & ~w_any_last;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_take       = r_out_valid & bus.out_ready;

  assign w_fin_valid  = r_dl_valid[MUL_LAT-1];
  assign w_fin_last   = r_dl_last[MUL_LAT-1];

  // ---------------------------------------------------------------------------
  // Accumulate datapath. In IDLE the frame starts from zero so the same adder
  // serves the first beat, middle beats and the closing beat.
  // ---------------------------------------------------------------------------
  assign w_prod_ext = ACC_W'(bus.prod);
  assign w_acc_base = (r_state == ACCUM) ? r_acc : '0;
  assign w_sum_full = {1'b0, w_acc_base} + {1'b0, w_prod_ext};

  // Saturation is sticky: once the frame has overflowed, every later sum
  // stays at all ones regardless of the incoming product.
  assign w_ovf_next = ((r_state == ACCUM) & r_ovf) | w_sum_full[ACC_W];
  assign w_acc_next = w_ovf_next ? '1 : w_sum_full[ACC_W-1:0];

  assign w_cnt_base = (r_state == ACCUM) ? r_cnt : 16'd0;
  assign w_cnt_next = (w_cnt_base == 16'hFFFF) ? 16'hFFFF : w_cnt_base + 16'd1;

  // ---------------------------------------------------------------------------
  // Delay line, frame FSM and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dl_valid  <= '0;
      r_dl_last   <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_count <= '0;
    end else begin
      // Only an accepted beat may mark a last, otherwise a refused last
      // would block in_ready for MUL_LAT cycles for nothing.
      r_dl_valid[0] <= w_accept;
      r_dl_last[0]  <= w_accept & bus.in_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
      end

      if (w_take) begin
        r_out_valid <= 1'b0;
      end

      if (w_fin_valid) begin
        if (w_fin_last) begin
          // A load on the same edge as a take wins, keeping out_valid high.
          r_out_valid <= 1'b1;
          r_out_data  <= w_acc_next;
          r_out_ovf   <= w_ovf_next;
          r_out_count <= w_cnt_next;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
          r_state     <= IDLE;
        end else begin
          r_acc       <= w_acc_next;
          r_cnt       <= w_cnt_next;
          r_ovf       <= w_ovf_next;
          r_state     <= ACCUM;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_count = r_out_count;
  assign o_dbg_state   = (r_state == ACCUM);

endmodule

// File: tb/tb_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_dot_accum
//   Drives beats (a, b, last) into a behavioural multiplier pipeline feeding
//   dot_accum. Every accepted beat updates a frame-level reference model that
//   pushes the expected result (sum, ovf, count, load cycle) into queues; an
//   independent monitor pops and compares whenever a result is taken or
//   loaded.
// -----------------------------------------------------------------------------
module tb_dot_accum;

  localparam int PROD_W  = 32;
  localparam int ACC_W   = 40;
  localparam int MUL_LAT = 2;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT and environment
  // ---------------------------------------------------------------------------
  dot_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();
  logic dbg_state;

  dot_accum #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;

  // Multiplier: a/b sampled on an edge, product visible MUL_LAT edges later
  // in front of the consuming edge.
  logic [PROD_W-1:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= PROD_W'(a) * PROD_W'(b);
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bus.prod = mul_pipe[MUL_LAT-1];

  logic rand_bp     = 1'b0;
  logic rand_ready  = 1'b1;
  logic ready_force = 1'b1;
  assign bus.out_ready = rand_bp ? rand_ready : ready_force;

  initial begin
    forever begin
      @(negedge clk);
      rand_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];
  logic [15:0]      exp_cnt_q[$];
  int               exp_cyc_q[$];

  logic [63:0] m_sum = 64'd0;
  int          m_cnt = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Frame sum as plain 64-bit arithmetic, clamped once at the end.
  function automatic void model_accept(input logic [63:0] p, input logic last, input int at_cyc);
    m_sum += p;
    m_cnt++;
    if (last) begin
      exp_q.push_back((m_sum > ACC_MAX) ? ACC_MAX[ACC_W-1:0] : m_sum[ACC_W-1:0]);
      exp_ovf_q.push_back(m_sum > ACC_MAX);
      exp_cnt_q.push_back((m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt));
      // Snapshot is before edge k; the result loads on edge k+MUL_LAT.
      exp_cyc_q.push_back(at_cyc + 1 + MUL_LAT);
      m_sum = 64'd0;
      m_cnt = 0;
    end
  endfunction

  // Monitor: snapshot 2 time units after each falling edge.
  initial begin
    logic             pv;
    logic             pt;
    logic [ACC_W-1:0] hd;
    logic             ho;
    logic [15:0]      hc;
    pv = 1'b0; pt = 1'b0; hd = '0; ho = 1'b0; hc = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0;
        pt = 1'b0;
      end else begin
        if (bus.out_valid && (!pv || pt)) begin
          if (exp_cyc_q.size() == 0) chk("unexpected_result", 1, 0);
          else chk("load_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
        end
        if (bus.out_valid && pv && !pt) begin
          chk("hold_data",  bus.out_data,  hd);
          chk("hold_ovf",   bus.out_ovf,   ho);
          chk("hold_count", bus.out_count, hc);
        end
        if (dut.r_dl_valid[MUL_LAT-1] && dut.r_dl_last[MUL_LAT-1])
          chk("result_reg_full_on_last", bus.out_valid & ~bus.out_ready, 0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) chk("take_without_expectation", 1, 0);
          else begin
            chk("out_data",  bus.out_data,  exp_q.pop_front());
            chk("out_ovf",   bus.out_ovf,   exp_ovf_q.pop_front());
            chk("out_count", bus.out_count, exp_cnt_q.pop_front());
          end
        end
        pv = bus.out_valid;
        pt = bus.out_valid & bus.out_ready;
        hd = bus.out_data;
        ho = bus.out_ovf;
        hc = bus.out_count;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [15:0] av, input logic [15:0] bv, input logic last);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      a = av;
      b = bv;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      #1;
      if (bus.in_ready) begin
        ok = 1'b1;
        model_accept(64'(av) * 64'(bv), last, cyc);
      end
    end
    chk("beat_accepted", ok, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut(input int n);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    m_sum = 64'd0;
    m_cnt = 0;
  endtask

  task automatic drain();
    rand_bp     = 1'b0;
    ready_force = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    idle(2);
    chk("drained", 64'(exp_q.size()), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          len;
    int          tw;

    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst_n        = 1'b0;

    // Reset held for 3 edges.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_out_ovf",   bus.out_ovf,   0);
    chk("rst_out_count", bus.out_count, 0);
    chk("rst_in_ready",  bus.in_ready,  0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_state",    dbg_state,    0);

    // Frame a=1..4, b=10 -> 100, count 4.
    for (int i = 1; i <= 4; i++) send_beat(16'(i), 16'd10, i == 4);
    drain();

    // Single full-scale beat.
    send_beat(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Backpressure: result A held, beat B refused until the take edge.
    ready_force = 1'b0;
    send_beat(16'd2, 16'd3, 1'b1);
    tw = 0;
    while (!bus.out_valid && tw < 20) begin
      @(negedge clk);
      #1;
      tw++;
    end
    chk("bp_a_valid", bus.out_valid, 1);
    fork
      send_beat(16'd5, 16'd5, 1'b1);
      begin
        repeat (4) begin
          @(negedge clk);
          #1;
          chk("bp_in_ready_low", bus.in_ready, 0);
          chk("bp_data_held",    bus.out_data, 6);
        end
        @(negedge clk);
        ready_force = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
      end
    join
    idle(4);
    drain();

    // Saturation: 257 full-scale beats, then a fresh 1x1 frame.
    for (int i = 0; i < 257; i++) send_beat(16'hFFFF, 16'hFFFF, i == 256);
    drain();
    send_beat(16'd1, 16'd1, 1'b1);
    drain();

    // Reset in the middle of a frame discards it.
    send_beat(16'd7, 16'd9, 1'b0);
    send_beat(16'd11, 16'd13, 1'b0);
    reset_dut(1);
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    send_beat(16'd3, 16'd5, 1'b1);
    drain();

    // Random frames under random result backpressure.
    rand_bp = 1'b1;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        rb = 16'($urandom);
        send_beat(ra, rb, i == len - 1);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    drain();

    chk("final_queue_empty", 64'(exp_cyc_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
